lutram_fifo64_ctrl: RTL and testbench

//  Single-clock 64-deep FIFO controller sequencing a RAM64M-style distributed RAM in

---
 rtl/lutram_fifo64_ctrl.sv | 142 ++++++++++++++
 tb/tb_lutram_fifo64_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_fifo64_ctrl.sv
// 64-deep single-clock FIFO controller for a RAM64M-style LUTRAM.
// Define LUTRAM_FIFO_ERR_EN to add sticky overflow/underflow flags.
module lutram_fifo64_ctrl #(
    parameter int DW         = 4,
    parameter int AF_LVL     = 60,
    parameter int AE_LVL     = 4,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          afull,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          aempty,
    output logic [6:0]    level,
    output logic          busy
`ifdef LUTRAM_FIFO_ERR_EN
    ,
    input  logic          err_clr,
    output logic          ovf,
    output logic          unf
`endif
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [5:0]    wr_ptr;
    logic [5:0]    rd_ptr;
    logic [5:0]    clr_cnt;
    logic [DW-1:0] mem [64];
    logic          run;
    logic          push;
    logic          pop;
    logic          we;
    logic [5:0]    waddr;
    logic [DW-1:0] wdata;
    logic [6:0]    level_nx;

    assign run  = (state == S_RUN);
    assign push = run & ~flush & wr_en & ~full;
    assign pop  = run & ~flush & rd_en & ~empty;

    always_comb begin
        level_nx = level;
        case ({push, pop})
            2'b10:   level_nx = level + 7'd1;
            2'b01:   level_nx = level - 7'd1;
            default: level_nx = level;
        endcase
    end

    // Shared write port: clear sequencer owns it outside RUN.
    assign we    = ~run | push;
    assign waddr = run ? wr_ptr : clr_cnt;
    assign wdata = run ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLR_ON_RST ? S_INIT : S_RUN;
            busy    <= CLR_ON_RST;
            full    <= CLR_ON_RST;
            empty   <= 1'b1;
            aempty  <= 1'b1;
            afull   <= 1'b0;
            level   <= 7'd0;
            wr_ptr  <= 6'd0;
            rd_ptr  <= 6'd0;
            clr_cnt <= 6'd0;
        end else begin
            unique case (state)
                S_INIT: begin
                    clr_cnt <= clr_cnt + 6'd1;
                    if (clr_cnt == 6'd63) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                        full  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        wr_ptr  <= 6'd0;
                        rd_ptr  <= 6'd0;
                        level   <= 7'd0;
                        empty   <= 1'b1;
                        aempty  <= 1'b1;
                        afull   <= 1'b0;
                        clr_cnt <= 6'd0;
                        if (CLR_ON_RST) begin
                            state <= S_INIT;
                            busy  <= 1'b1;
                            full  <= 1'b1;
                        end else begin
                            full  <= 1'b0;
                        end
                    end else begin
                        if (push)
                            wr_ptr <= wr_ptr + 6'd1;
                        if (pop)
                            rd_ptr <= rd_ptr + 6'd1;
                        level  <= level_nx;
                        full   <= (level_nx == 7'd64);
                        empty  <= (level_nx == 7'd0);
                        afull  <= (level_nx >= 7'(AF_LVL));
                        aempty <= (level_nx <= 7'(AE_LVL));
                    end
                end
            endcase
        end
    end

`ifdef LUTRAM_FIFO_ERR_EN
    // Clear first, then set, so a new error wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (err_clr || (run && flush)) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (run && !flush && wr_en && full)
                ovf <= 1'b1;
            if (run && !flush && rd_en && empty)
                unf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lutram_fifo64_ctrl.sv
// Bench for lutram_fifo64_ctrl: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_lutram_fifo64_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       full, afull, empty, aempty, busy;
    logic [3:0] rd_data;
    logic [6:0] level;
`ifdef LUTRAM_FIFO_ERR_EN
    logic       err_clr = 1'b0;
    logic       ovf, unf;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lutram_fifo64_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .afull   (afull),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .aempty  (aempty),
        .level   (level),
        .busy    (busy)
`ifdef LUTRAM_FIFO_ERR_EN
        ,
        .err_clr (err_clr),
        .ovf     (ovf),
        .unf     (unf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, clear phase as a countdown.
    logic [3:0] q[$];
    int         m_init = 64;
    bit         m_push, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_init = 64;
        end else if (m_init > 0) begin
            m_init--;
        end else if (flush) begin
            q.delete();
            m_init = 64;
        end else begin
            m_push = wr_en && (q.size() < 64);
            m_pop  = rd_en && (q.size() > 0);
            if (m_pop)
                void'(q.pop_front());
            if (m_push)
                q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_init > 0);
            chk("full", full, (m_init > 0) || (q.size() == 64));
            chk("empty", empty, q.size() == 0);
            chk("level", level, q.size());
            chk("afull", afull, q.size() >= 60);
            chk("aempty", aempty, q.size() <= 4);
            if (q.size() > 0)
                chk("rd_data", rd_data, q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [3:0] pat(input int i, input int r);
        return 4'((i * 5) + (r * 3) + 1);
    endfunction

    int n;

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_full", full, 1);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        wait_idle(n);
        chk("init_cycles", n, 64);
        chk("init_full", full, 0);
        chk("init_empty", empty, 1);
        chk("init_aempty", aempty, 1);

        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1;
            wr_data = 4'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("push10_level", level, 10);
        for (int i = 1; i <= 10; i++) begin
            chk("pop10_data", rd_data, i);
            chk("pop10_level", level, 11 - i);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("pop10_empty", empty, 1);
        chk("pop10_level0", level, 0);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 64; i++) begin
                wr_en = 1'b1;
                wr_data = pat(i, r);
                tick();
                if (i == 58)
                    chk("afull_59", afull, 0);
                if (i == 59)
                    chk("afull_60", afull, 1);
            end
            chk("fill_full", full, 1);
            chk("fill_level", level, 64);
            wr_data = 4'hF;
            tick();
            wr_en = 1'b0;
            chk("push65_level", level, 64);
`ifdef LUTRAM_FIFO_ERR_EN
            chk("ovf_set", ovf, 1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk("ovf_clr", ovf, 0);
`endif
            for (int i = 0; i < 64; i++) begin
                chk("drain_data", rd_data, pat(i, r));
                rd_en = 1'b1;
                tick();
            end
            rd_en = 1'b0;
            chk("drain_empty", empty, 1);
        end

        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1;
            wr_data = pat(i, 2);
            tick();
        end
        rd_en = 1'b1;
        tick();
        chk("both_full_level", level, 63);
        chk("both_full_flag", full, 0);
        wr_en = 1'b0;
        repeat (58) tick();
        chk("drain_to5", level, 5);
        wr_en = 1'b1;
        tick();
        chk("both_5_level", level, 5);
        wr_en = 1'b0;
        repeat (5) tick();
        rd_en = 1'b0;
        chk("both_empty", empty, 1);

        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1;
            wr_data = pat(i, 3);
            tick();
        end
        chk("pre_flush_level", level, 20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);
        chk("flush_busy", busy, 1);
        wait_idle(n);
        chk("flush_cycles", n, 64);

        for (int i = 0; i < 30; i++) begin
            wr_en = 1'b1;
            wr_data = pat(i, 4);
            tick();
        end
        chk("burst_level", level, 30);
        rst = 1'b1;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_busy", busy, 1);
        chk("midrst_full", full, 1);
        chk("midrst_afull", afull, 0);
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
        wait_idle(n);
        chk("rst2_cycles", n, 64);
`ifdef LUTRAM_FIFO_ERR_EN
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_set", unf, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("unf_clr", unf, 0);
`endif
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
